// File: rtl/weapons_pkg.sv
// Shared types and constants for the weapons fire controller.
package weapons_pkg;

    localparam int unsigned AMMO_W           = 9;
    localparam int unsigned AMMO_MAX_DEFAULT = 500;
    localparam logic [3:0]  MODE_ATTACK      = 4'b0010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIRE,
        ST_COOL,
        ST_RELOAD
    } fire_state_t;

endpackage

// File: rtl/weapons_fire_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from the pointer with wrap.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt
);

    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        o_gnt   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_idx = PTR_W'((32'(i_ptr) + i) % N_REQ);
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/weapons_fire_ctrl.sv
// Weapons fire controller: arbitrates station fire requests, tracks ammo,
// enforces a post-shot cooldown and handles saturating magazine reloads.
module weapons_fire_ctrl
    import weapons_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned AMMO_MAX = AMMO_MAX_DEFAULT,
    parameter int unsigned COOLDOWN = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        mode_selector,
    input  logic [N_REQ-1:0]  fire_req,
    input  logic              reload,
    input  logic [AMMO_W-1:0] reload_amt,
    output logic [N_REQ-1:0]  grant,
    output logic [AMMO_W-1:0] ammo,
    output logic              empty,
    output logic              busy,
    output logic              error
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(COOLDOWN - 1);
    localparam logic [AMMO_W-1:0] AMMO_CEIL = AMMO_W'(AMMO_MAX);

    fire_state_t       r_state;
    logic [N_REQ-1:0]  r_grant;
    logic [AMMO_W-1:0] r_ammo;
    logic              r_error;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  r_win;
    logic [CNT_W-1:0]  r_cnt;
    logic [AMMO_W-1:0] r_amt;

    logic [N_REQ-1:0]  w_gnt;
    logic [PTR_W-1:0]  w_win;
    logic [AMMO_W:0]   w_sum;
    logic [AMMO_W-1:0] w_reloaded;
    logic              w_can_fire;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .i_req (fire_req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt)
    );

    always_comb begin
        w_win = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_win = PTR_W'(i);
            end
        end
    end

    // 10-bit sum so the saturation compare cannot wrap.
    assign w_sum      = {1'b0, r_ammo} + {1'b0, r_amt};
    assign w_reloaded = (w_sum > {1'b0, AMMO_CEIL}) ? AMMO_CEIL : w_sum[AMMO_W-1:0];
    assign w_can_fire = (mode_selector == MODE_ATTACK) && (r_ammo != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_error <= 1'b0;
            r_ammo  <= AMMO_CEIL;
            r_ptr   <= '0;
            r_win   <= '0;
            r_cnt   <= '0;
            r_amt   <= '0;
        end else begin
            r_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (reload) begin
                        r_amt   <= reload_amt;
                        r_state <= ST_RELOAD;
                    end else if (|fire_req) begin
                        if (w_can_fire) begin
                            r_grant <= w_gnt;
                            r_win   <= w_win;
                            r_state <= ST_FIRE;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                ST_FIRE: begin
                    r_ammo  <= r_ammo - AMMO_W'(1);
                    r_grant <= '0;
                    r_ptr   <= (r_win == PTR_LAST) ? '0 : r_win + PTR_W'(1);
                    r_cnt   <= CNT_LOAD;
                    r_state <= ST_COOL;
                end
                ST_COOL: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RELOAD: begin
                    r_ammo  <= w_reloaded;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign ammo  = r_ammo;
    assign error = r_error;
    assign empty = (r_ammo == '0);
    assign busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_weapons_fire_ctrl.sv
// Bench for weapons_fire_ctrl: timer-based reference model plus directed scenarios.
module tb_weapons_fire_ctrl;

    localparam int N    = 4;
    localparam int MAXA = 500;
    localparam int CD   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] mode_selector = 4'b0010;
    logic [3:0] fire_req = '0;
    logic       reload = 1'b0;
    logic [8:0] reload_amt = '0;
    logic [3:0] grant;
    logic [8:0] ammo;
    logic       empty;
    logic       busy;
    logic       error;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    weapons_fire_ctrl #(
        .N_REQ    (N),
        .AMMO_MAX (MAXA),
        .COOLDOWN (CD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mode_selector (mode_selector),
        .fire_req      (fire_req),
        .reload        (reload),
        .reload_amt    (reload_amt),
        .grant         (grant),
        .ammo          (ammo),
        .empty         (empty),
        .busy          (busy),
        .error         (error)
    );

    always #5 clk = ~clk;

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a shot window, a cooldown timer and a pending reload.
    int         m_ammo, m_ptr, m_win, m_cool, m_rel_amt;
    bit         m_shot, m_rel, m_err;
    logic [3:0] m_grant;

    function automatic int rr_pick(logic [3:0] req, int ptr);
        for (int i = 0; i < N; i++) begin
            if (req[(ptr + i) % N]) return (ptr + i) % N;
        end
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ammo <= MAXA; m_ptr <= 0; m_win <= 0; m_cool <= 0; m_rel_amt <= 0;
            m_shot <= 0; m_rel <= 0; m_err <= 0; m_grant <= '0;
        end else begin
            m_err <= 0;
            if (m_shot) begin
                m_ammo  <= m_ammo - 1;
                m_ptr   <= (m_win + 1) % N;
                m_shot  <= 0;
                m_grant <= '0;
                m_cool  <= CD;
            end else if (m_cool > 0) begin
                m_cool <= m_cool - 1;
            end else if (m_rel) begin
                m_ammo <= (m_ammo + m_rel_amt > MAXA) ? MAXA : m_ammo + m_rel_amt;
                m_rel  <= 0;
            end else if (reload) begin
                m_rel     <= 1;
                m_rel_amt <= int'(reload_amt);
            end else if (fire_req != 0) begin
                if (mode_selector == 4'b0010 && m_ammo > 0) begin
                    m_shot  <= 1;
                    m_win   <= rr_pick(fire_req, m_ptr);
                    m_grant <= 4'(1 << rr_pick(fire_req, m_ptr));
                end else begin
                    m_err <= 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("grant", int'(grant), int'(m_grant));
            check("ammo", int'(ammo), m_ammo);
            check("empty", int'(empty), int'(m_ammo == 0));
            check("busy", int'(busy), int'(m_shot || m_cool > 0 || m_rel));
            check("error", int'(error), int'(m_err));
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic wait_ammo(int target, int bound);
        int k = 0;
        while (int'(ammo) != target && k < bound) begin
            tick();
            k++;
        end
        check("wait_ammo", int'(ammo), target);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rr_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        do_reset();
        check("rst_ammo", int'(ammo), 500);
        check("rst_grant", int'(grant), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_empty", int'(empty), 0);
        check("rst_error", int'(error), 0);

        // Single station held: grants every COOLDOWN+2 cycles.
        fire_req = 4'b0001;
        for (int c = 1; c <= 12; c++) begin
            tick();
            check("spacing_grant", int'(grant), (c == 1 || c == 6 || c == 11) ? 1 : 0);
            if (c == 2)  check("ammo_499", int'(ammo), 499);
            if (c == 7)  check("ammo_498", int'(ammo), 498);
            if (c == 12) check("ammo_497", int'(ammo), 497);
        end
        fire_req = '0;
        tick(5);

        // All stations held: round-robin rotation.
        do_reset();
        fire_req = 4'b1111;
        for (int c = 1; c <= 21; c++) begin
            tick();
            check("rr_error", int'(error), 0);
            if ((c - 1) % 5 == 0) check("rr_grant", int'(grant), int'(rr_seq[(c - 1) / 5]));
        end
        fire_req = '0;
        tick(6);

        // Wrong mode: error every cycle, no shot.
        do_reset();
        mode_selector = 4'b0100;
        fire_req = 4'b0010;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check("mode_error", int'(error), 1);
            check("mode_grant", int'(grant), 0);
            check("mode_ammo", int'(ammo), 500);
        end
        fire_req = '0;
        mode_selector = 4'b0010;
        tick();
        check("mode_error_clr", int'(error), 0);

        // Drain to empty, refused request, then reload.
        fire_req = 4'b0001;
        wait_ammo(1, 3000);
        fire_req = '0;
        tick(6);
        check("drain_ammo1", int'(ammo), 1);
        check("drain_empty0", int'(empty), 0);
        fire_req = 4'b0001;
        tick();
        check("last_grant", int'(grant), 1);
        fire_req = '0;
        tick();
        check("empty_ammo", int'(ammo), 0);
        check("empty_flag", int'(empty), 1);
        tick(4);
        fire_req = 4'b0001;
        tick();
        check("empty_error", int'(error), 1);
        check("empty_nogrant", int'(grant), 0);
        fire_req = '0;
        tick();
        check("empty_error_clr", int'(error), 0);
        reload = 1'b1;
        reload_amt = 9'd20;
        tick();
        check("reload_busy", int'(busy), 1);
        reload = 1'b0;
        tick();
        check("reload_ammo20", int'(ammo), 20);
        check("reload_empty0", int'(empty), 0);

        // Reload and fire in the same cycle: reload wins, saturates.
        do_reset();
        fire_req = 4'b0001;
        wait_ammo(490, 100);
        fire_req = '0;
        tick(6);
        reload = 1'b1;
        reload_amt = 9'd50;
        fire_req = 4'b0001;
        tick();
        check("prio_busy", int'(busy), 1);
        check("prio_nogrant", int'(grant), 0);
        reload = 1'b0;
        tick();
        check("prio_sat", int'(ammo), 500);
        tick();
        check("prio_grant", int'(grant), 1);
        tick();
        check("prio_ammo499", int'(ammo), 499);
        fire_req = '0;
        tick(5);

        // Reset mid-FIRE restores ammo and pointer.
        do_reset();
        fire_req = 4'b0010;
        tick();
        check("pre_grant", int'(grant), 2);
        fire_req = '0;
        tick(6);
        fire_req = 4'b0010;
        tick();
        check("fire_grant", int'(grant), 2);
        #2 rst = 1'b1;
        #1;
        check("async_grant", int'(grant), 0);
        check("async_ammo", int'(ammo), 500);
        check("async_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        fire_req = 4'b0110;
        tick();
        check("post_rst_grant", int'(grant), 2);
        fire_req = '0;
        tick(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
